// File: rtl/iir_tdf_seq.sv
// Time-multiplexed transposed direct-form II IIR with runtime-loadable coefficients.
// Define IIR_SAT_EN to clamp y to the DATA_W range and report clipping on sat_flag.
module iir_tdf_seq #(
  parameter int unsigned ORDER  = 12,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned COEF_W = 32,
  parameter int unsigned ACC_W  = 64,
  parameter int unsigned FRAC   = 20,
  localparam int unsigned ADDR_W = $clog2(ORDER + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] y,
  output logic                     sat_flag,
  input  logic                     coef_we,
  input  logic                     coef_sel,
  input  logic [ADDR_W-1:0]        coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  output logic                     busy
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;

  typedef enum logic [1:0] {StIdle, StCalcY, StUpdate} state_e;

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        k_q, k_d;
  logic signed [COEF_W-1:0] b_q [0:ORDER];
  logic signed [COEF_W-1:0] a_q [1:ORDER];
  logic signed [ACC_W-1:0]  s_q [1:ORDER];
  logic signed [DATA_W-1:0] x_q, y_q;
  logic                     out_valid_q, sat_q;

  // Coefficient write that arrived together with a sample; applied once that sample is done.
  logic                     pend_q, pend_sel_q;
  logic [ADDR_W-1:0]        pend_addr_q;
  logic signed [COEF_W-1:0] pend_data_q;

  logic                     accept, proceed, last_k, wr_ok, pend_set;
  logic                     cw_en, cw_sel;
  logic [ADDR_W-1:0]        cw_addr;
  logic signed [COEF_W-1:0] cw_data;
  logic signed [COEF_W-1:0] b_sel, a_sel;
  logic signed [ACC_W-1:0]  s_nxt, sum;
  logic signed [PROD_W-1:0] prod_b, prod_a;
  logic signed [DATA_W-1:0] y_new;
  logic                     sat_new;

  assign in_ready  = reset & (state_q == StIdle) & ~clr;
  assign accept    = in_valid & in_ready;
  assign busy      = (state_q != StIdle);
  assign proceed   = ~out_valid_q | out_ready;
  assign last_k    = (k_q == ADDR_W'(ORDER));
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign sat_flag  = sat_q;

  // a[0] is implicitly 1.0 and has no storage.
  assign wr_ok    = coef_we & (coef_addr <= ADDR_W'(ORDER)) & ~(coef_sel & (coef_addr == '0));
  assign pend_set = ~busy & wr_ok & accept;

  always_comb begin
    cw_en   = 1'b0;
    cw_sel  = coef_sel;
    cw_addr = coef_addr;
    cw_data = coef_wdata;
    if (pend_q && busy && (state_d == StIdle)) begin
      cw_en   = 1'b1;
      cw_sel  = pend_sel_q;
      cw_addr = pend_addr_q;
      cw_data = pend_data_q;
    end else if (!busy && wr_ok && !accept) begin
      cw_en = 1'b1;
    end
  end

  // Shared datapath: CALC_Y uses b[0] and s[1]; UPDATE(k) uses b[k], a[k] and s[k+1].
  always_comb begin
    b_sel = b_q[0];
    a_sel = '0;
    s_nxt = s_q[1];
    if (state_q == StUpdate) begin
      b_sel = b_q[k_q];
      a_sel = a_q[k_q];
      s_nxt = '0;
      for (int i = 1; i < ORDER; i++) begin
        if (k_q == ADDR_W'(i)) s_nxt = s_q[i+1];
      end
    end
  end

  assign prod_b = PROD_W'(b_sel) * PROD_W'(x_q);
  assign prod_a = PROD_W'(a_sel) * PROD_W'(y_q);
  assign sum    = ACC_W'(prod_b) + s_nxt - ACC_W'(prod_a);

`ifdef IIR_SAT_EN
  localparam logic signed [ACC_W-1:0] YMax = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] YMin = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = sum >>> FRAC;
    y_new   = shifted[DATA_W-1:0];
    sat_new = 1'b0;
    if (shifted > YMax) begin
      y_new   = YMax[DATA_W-1:0];
      sat_new = 1'b1;
    end else if (shifted < YMin) begin
      y_new   = YMin[DATA_W-1:0];
      sat_new = 1'b1;
    end
  end
`else
  assign y_new   = DATA_W'(sum >>> FRAC);
  assign sat_new = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StCalcY;
      end
      StCalcY: begin
        if (proceed) begin
          state_d = StUpdate;
          k_d     = ADDR_W'(1);
        end
      end
      StUpdate: begin
        if (last_k) state_d = StIdle;
        else        k_d     = k_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
    if (clr) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      k_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      for (int i = 1; i <= ORDER; i++) s_q[i] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (accept) x_q <= x;
      if (clr) begin
        out_valid_q <= 1'b0;
        sat_q       <= 1'b0;
        for (int i = 1; i <= ORDER; i++) s_q[i] <= '0;
      end else begin
        if (state_q == StCalcY && proceed) begin
          y_q         <= y_new;
          sat_q       <= sat_new;
          out_valid_q <= 1'b1;
        end else if (out_ready) begin
          out_valid_q <= 1'b0;
        end
        if (state_q == StUpdate) s_q[k_q] <= sum;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i <= ORDER; i++) b_q[i] <= '0;
      for (int i = 1; i <= ORDER; i++) a_q[i] <= '0;
      pend_q      <= 1'b0;
      pend_sel_q  <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
    end else begin
      if (cw_en) begin
        if (cw_sel) a_q[cw_addr] <= cw_data;
        else        b_q[cw_addr] <= cw_data;
        pend_q <= 1'b0;
      end
      if (pend_set) begin
        pend_q      <= 1'b1;
        pend_sel_q  <= coef_sel;
        pend_addr_q <= coef_addr;
        pend_data_q <= coef_wdata;
      end
    end
  end

endmodule
